// File: rtl/bintree_pkg.sv
// bintree_pkg: shared op encodings, converter mode constants and sequencer state enum
package bintree_pkg;
  localparam logic [1:0] OP_SEND = 2'd1;
  localparam logic [1:0] OP_RECV = 2'd2;
  localparam logic [1:0] OP_LOAD = 2'd3;
  localparam logic [1:0] MODE_SHIFT_OUT = 2'd0;
  localparam logic [1:0] MODE_SHIFT_IN = 2'd1;
  localparam logic [1:0] MODE_LOAD = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_START, ST_SHIFT, ST_CAPTURE, ST_RESP} state_t;
endpackage

// File: rtl/bintree_link_sequencer.sv
// bintree_link_sequencer: host cmd (valid/ready) -> converter mode/start control, finish wait with timeout, response (valid/ready) with captured word
module bintree_link_sequencer
  import bintree_pkg::*;
#(
  parameter int SIZE = 1,
  parameter int MAX_WORD_LENGTH = 32,
  parameter int LENGTH = 32,
  parameter int TIMEOUT_MARGIN = 8,
  localparam int DW = 4 * MAX_WORD_LENGTH * SIZE
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [1:0]    rsp_op,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_data,
  output logic [1:0]    conv_mode,
  output logic          conv_start,
  input  logic          conv_finish,
  output logic [DW-1:0] conv_parallel_in,
  input  logic [DW-1:0] conv_parallel_out
);
  localparam int LIMIT = LENGTH + 2 + TIMEOUT_MARGIN;
  localparam int TW = $clog2(LIMIT + 1);
  state_t r_state, w_next;
  logic [TW-1:0] r_timer;
  logic w_acc, w_tmo;
  logic [1:0] w_op;
  always_comb begin
    w_acc = cmd_valid && cmd_ready;
    w_tmo = r_state == ST_SHIFT && r_timer == TW'(LIMIT - 1);
    w_op = r_state == ST_IDLE ? cmd_op : rsp_op;
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = !w_acc ? ST_IDLE : cmd_op == 2'd0 ? ST_RESP : cmd_op == OP_RECV ? ST_START : ST_LOAD;
      ST_LOAD: w_next = rsp_op == OP_LOAD ? ST_RESP : ST_START;
      ST_START: w_next = ST_SHIFT;
      ST_SHIFT: w_next = conv_finish ? (rsp_op == OP_RECV ? ST_CAPTURE : ST_RESP) : w_tmo ? ST_RESP : ST_SHIFT;
      ST_CAPTURE: w_next = ST_RESP;
      ST_RESP: w_next = rsp_ready ? ST_IDLE : ST_RESP;
      default: w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_op <= 2'd0;
      rsp_err <= 1'b0;
      rsp_data <= '0;
      conv_mode <= MODE_HOLD;
      conv_start <= 1'b0;
      conv_parallel_in <= '0;
    end else begin
      r_state <= w_next;
      r_timer <= (r_state == ST_START || r_state == ST_SHIFT) ? r_timer + 1'b1 : '0;
      cmd_ready <= w_next == ST_IDLE;
      rsp_valid <= w_next == ST_RESP;
      conv_start <= w_next == ST_START;
      conv_mode <= w_next == ST_LOAD ? MODE_LOAD :
                   (w_next == ST_START || w_next == ST_SHIFT) ? (w_op == OP_RECV ? MODE_SHIFT_IN : MODE_SHIFT_OUT) :
                   MODE_HOLD;
      if (w_acc) begin
        rsp_op <= cmd_op;
        rsp_err <= cmd_op == 2'd0;
        rsp_data <= '0;
        if (cmd_op[0]) conv_parallel_in <= cmd_data;
      end
      if (w_tmo && !conv_finish) rsp_err <= 1'b1;
      if (r_state == ST_CAPTURE) rsp_data <= conv_parallel_out;
    end
  end
endmodule

// File: tb/tb_bintree_link_sequencer.sv
// tb_bintree_link_sequencer: directed checks of bintree_link_sequencer against a small behavioural converter
module tb_bintree_link_sequencer;
  localparam int DW = 128;
  localparam int LENGTH = 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, conv_start, conv_finish;
  logic [1:0] cmd_op, rsp_op, conv_mode;
  logic [DW-1:0] cmd_data, rsp_data, conv_parallel_in, conv_parallel_out;
  logic fin, fin_en, spur;
  logic [DW-1:0] rx_word;
  int cnt;
  int n_vec = 0;
  int n_err = 0;
  assign conv_finish = fin | spur;
  bintree_link_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .conv_mode(conv_mode), .conv_start(conv_start), .conv_finish(conv_finish),
    .conv_parallel_in(conv_parallel_in), .conv_parallel_out(conv_parallel_out)
  );
  // finish pulses LENGTH+1 cycles after start; a shift-in's final word lands one cycle after finish
  always @(posedge clk) begin
    if (!reset) begin
      cnt <= 0;
      fin <= 1'b0;
      conv_parallel_out <= '0;
    end else begin
      fin <= fin_en && cnt == 1;
      cnt <= conv_start ? LENGTH : (cnt != 0 ? cnt - 1 : 0);
      if (fin && conv_mode == 2'd1) conv_parallel_out <= rx_word;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [DW-1:0] d);
    cmd_op = op;
    cmd_data = d;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
  endtask
  task automatic take(input string tag);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, rsp_valid, 0);
    chk({tag, "_idle_ready"}, cmd_ready, 1);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_op"}, rsp_op, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_mode"}, conv_mode, 3);
    chk({tag, "_start"}, conv_start, 0);
    chk({tag, "_par_in"}, conv_parallel_in, 0);
  endtask
  task automatic run_send(input string tag, input logic [DW-1:0] d);
    int n, bad;
    issue(2'd1, d);
    chk({tag, "_load_mode"}, conv_mode, 2);
    chk({tag, "_load_data"}, conv_parallel_in, d);
    tick;
    chk({tag, "_start"}, conv_start, 1);
    chk({tag, "_start_mode"}, conv_mode, 0);
    tick;
    n = 0;
    bad = 0;
    while (!conv_finish && n < 80) begin
      if (conv_start || conv_mode != 2'd0) bad++;
      tick;
      n++;
    end
    chk({tag, "_finish_lat"}, n, 32);
    chk({tag, "_shift_clean"}, bad, 0);
    tick;
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_op"}, rsp_op, 1);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_no_restart"}, conv_start, 0);
    take(tag);
  endtask
  initial begin
    int n;
    logic [DW-1:0] d_load, d_send;
    d_load = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    d_send = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    rx_word = {16{8'hA5}};
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_data = '0;
    rsp_ready = 1'b0;
    fin_en = 1'b1;
    spur = 1'b0;
    tick;
    tick;
    chk_reset("reset");
    reset = 1'b1;
    tick;
    chk("post_reset_ready", cmd_ready, 1);
    issue(2'd3, d_load);
    chk("load_mode", conv_mode, 2);
    chk("load_data", conv_parallel_in, d_load);
    chk("load_no_rsp", rsp_valid, 0);
    chk("load_busy", cmd_ready, 0);
    tick;
    chk("load_rsp_valid", rsp_valid, 1);
    chk("load_rsp_err", rsp_err, 0);
    chk("load_rsp_data", rsp_data, 0);
    chk("load_rsp_op", rsp_op, 3);
    chk("load_mode_hold", conv_mode, 3);
    take("load");
    run_send("send", d_send);
    issue(2'd2, '0);
    chk("recv_start", conv_start, 1);
    chk("recv_start_mode", conv_mode, 1);
    tick;
    chk("recv_shift_mode", conv_mode, 1);
    n = 0;
    while (!conv_finish && n < 80) begin
      tick;
      n++;
    end
    chk("recv_finish_lat", n, 32);
    tick;
    chk("recv_capture_mode", conv_mode, 3);
    chk("recv_capture_no_rsp", rsp_valid, 0);
    tick;
    chk("recv_rsp_valid", rsp_valid, 1);
    chk("recv_rsp_data", rsp_data, {16{8'hA5}});
    chk("recv_rsp_op", rsp_op, 2);
    chk("recv_rsp_err", rsp_err, 0);
    take("recv");
    fin_en = 1'b0;
    issue(2'd1, d_send);
    tick;
    chk("tmo_start", conv_start, 1);
    n = 0;
    while (!rsp_valid && n < 80) begin
      tick;
      n++;
    end
    chk("tmo_latency", n, 42);
    chk("tmo_rsp_err", rsp_err, 1);
    chk("tmo_mode", conv_mode, 3);
    chk("tmo_rsp_op", rsp_op, 1);
    take("tmo");
    fin_en = 1'b1;
    spur = 1'b1;
    tick;
    spur = 1'b0;
    chk("spur_idle_ready", cmd_ready, 1);
    chk("spur_idle_no_rsp", rsp_valid, 0);
    chk("spur_idle_mode", conv_mode, 3);
    chk("spur_idle_start", conv_start, 0);
    issue(2'd0, d_load);
    chk("rsvd_rsp_valid", rsp_valid, 1);
    chk("rsvd_rsp_err", rsp_err, 1);
    chk("rsvd_rsp_op", rsp_op, 0);
    chk("rsvd_rsp_data", rsp_data, 0);
    for (int i = 0; i < 5; i++) begin
      spur = i == 2;
      tick;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    spur = 1'b0;
    chk("bp_rsp_err", rsp_err, 1);
    take("rsvd");
    issue(2'd1, d_send);
    tick;
    tick;
    for (int i = 0; i < 10; i++) tick;
    reset = 1'b0;
    tick;
    chk_reset("abort");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort_no_rsp", rsp_valid, 0);
    end
    chk("abort_ready", cmd_ready, 1);
    run_send("resend", d_load);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bintree_link_sequencer.md
Name: bintree_link_sequencer

Overview:
- Command-driven sequencer that sits directly upstream of the Parallel_Serial_Converter in each BinTree leaf/node.
- Accepts host transfer commands (LOAD, SEND, RECEIVE) over a valid/ready channel and drives the converter's mode/start controls.
- Waits for the converter's finish pulse and returns a response. On RECEIVE, the response carries the captured parallel word.
- Guards against a missing finish with a timeout.

Parameters:
- SIZE, 1, lane-group count; must match the converter. Data width DW = 4*MAX_WORD_LENGTH*SIZE.
- MAX_WORD_LENGTH, 32, per-lane word storage; must match the converter.
- LENGTH, 32, serial transfer length in cycles; must match the converter.
- TIMEOUT_MARGIN, 8, extra cycles beyond LENGTH+2 before a transfer is declared failed.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  1=SEND, 2=RECEIVE, 3=LOAD, 0=reserved.
- cmd_data  in  DW  word for SEND/LOAD.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_op  out  2  echo of the completed op.
- rsp_err  out  1  1 = timeout or reserved op.
- rsp_data  out  DW  captured word (RECEIVE); 0 otherwise.
- conv_mode  out  2  converter mode: 0=shift out, 1=shift in, 2=parallel load, 3=hold.
- conv_start  out  1  one-cycle start pulse to the converter.
- conv_finish  in  1  converter finish pulse.
- conv_parallel_in  out  DW  drives the converter parallel_data_in.
- conv_parallel_out  in  DW  converter parallel_data_out.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, cmd_ready=0 during reset, rsp_valid=0, rsp_op=0, rsp_err=0, rsp_data=0, conv_mode=3, conv_start=0, conv_parallel_in=0, timer=0.
- All outputs are registered.
- IDLE:
  - cmd_ready=1, conv_mode=3.
  - On cmd_valid&&cmd_ready, latch op and data.
  - op 3 or 1 -> LOAD.
  - op 2 -> START.
  - op 0 -> RESP with rsp_err=1.
- LOAD (1 cycle):
  - conv_mode=2, conv_parallel_in=latched data.
  - op 3 -> RESP; op 1 -> START.
- START (1 cycle):
  - conv_start=1.
  - conv_mode=0 (SEND) or 1 (RECEIVE).
  - timer cleared. Next state SHIFT.
- SHIFT:
  - conv_mode held at the START value; conv_start=0; timer increments each cycle.
  - On conv_finish: SEND -> RESP; RECEIVE -> CAPTURE.
  - If timer reaches LENGTH+2+TIMEOUT_MARGIN without finish: RESP with rsp_err=1, conv_mode=3.
  - If finish and timeout occur in the same cycle, finish wins.
- CAPTURE (1 cycle):
  - conv_mode=3.
  - rsp_data <= conv_parallel_out, sampled one cycle after finish so the converter's last lane write has landed. Next state RESP.
- RESP:
  - rsp_valid=1; rsp_op, rsp_err and rsp_data are stable until rsp_ready.
  - On rsp_valid&&rsp_ready -> IDLE. rsp_valid drops the next cycle.
  - cmd_ready=0 until back in IDLE; no command is accepted in the cycle the response is taken.
- conv_finish outside SHIFT is ignored. This covers the spurious finish the converter emits shortly after its own reset.
- Reset asserted mid-transfer aborts immediately to the reset values. No response is produced for the aborted command.
- Latency, SEND (accept at cycle 0): LOAD@1, START@2, SHIFT from @3; RESP the cycle after finish.
- Latency, LOAD: RESP@2.
- Latency, RECEIVE: START@1; RESP two cycles after finish.
- Timer width: clog2(LENGTH+3+TIMEOUT_MARGIN) bits, no wrap within a transfer.

Decomposition:
- Shared package bintree_pkg holds:
  - op encodings OP_SEND=1, OP_RECV=2, OP_LOAD=3;
  - converter mode constants MODE_SHIFT_OUT=0, MODE_SHIFT_IN=1, MODE_LOAD=2, MODE_HOLD=3;
  - the state enum.
- Single module, no sub-module; the timeout counter is inline.

Test Plan:
- LOAD: op=3, data=128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF. Required: conv_mode=2 for exactly 1 cycle with conv_parallel_in equal to that data, then rsp_valid@2 with rsp_err=0 and rsp_data=0.
- SEND against a real converter (SIZE=1, LENGTH=32): single conv_start pulse@2, conv_mode=0 throughout SHIFT. Required: response the cycle after finish, rsp_err=0, no second start.
- RECEIVE with a loopback converter preloaded with 128'hA5A5...A5: rsp_data must equal conv_parallel_out sampled the cycle after finish, and rsp_op=2.
- Timeout: conv_finish tied 0. Required: rsp_err=1 exactly LENGTH+2+TIMEOUT_MARGIN=42 cycles after START, conv_mode=3, then accepts the next command.
- Backpressure plus reserved op: op=0. Required: rsp_err=1. Holding rsp_ready=0 for 5 cycles keeps rsp_valid=1 and cmd_ready=0; a spurious conv_finish in IDLE/RESP causes no state change.
- Reset mid-SHIFT: deassert reset for one cycle at SHIFT+10. Required: all outputs at reset values the next cycle, no response emitted, and the next SEND completes normally.
